// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I constants and LSU state type
package rv32_pkg;

    // Load/store width encodings from instruction[14:12]
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Major opcode field instruction[6:2]
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    // Error causes reported on err_cause_o
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication, access checks, load extraction
module lsu_align
    import rv32_pkg::*;
(
    input  logic        i_load,
    input  logic [2:0]  i_fun3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    output logic        o_illegal,
    output logic [31:0] o_rdata_ext
);

    logic [31:0] w_shifted;

    // Bring the addressed byte/half down to bit 0 before extension
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // Decode access width; unsigned widths exist only for loads
    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        o_rdata_ext  = w_shifted;
        case (i_fun3)
            F3_B: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_wdata[7:0]}};
                o_rdata_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_H: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
                o_rdata_ext  = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_W: begin
                o_be         = 4'b1111;
                o_misaligned = |i_addr_lo;
                o_rdata_ext  = i_rdata;
            end
            F3_BU: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_illegal   = ~i_load;
                o_rdata_ext = {24'd0, w_shifted[7:0]};
            end
            F3_HU: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_illegal    = ~i_load;
                o_misaligned = i_addr_lo[0];
                o_rdata_ext  = {16'd0, w_shifted[15:0]};
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store sequencer for the RV32I data port
module lsu_ctrl
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_load_i,
    input  logic [2:0]  req_fun3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_valid_o,
    output logic [1:0]  err_cause_o,
    output logic [31:0] err_addr_o,
    output logic        busy_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e     r_state;
    logic           r_ready;
    logic           r_load;
    logic [2:0]     r_fun3;
    logic [31:0]    r_addr;
    logic [4:0]     r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic           r_mem_req;
    logic           r_mem_we;
    logic [3:0]     r_mem_be;
    logic [31:0]    r_mem_addr;
    logic [31:0]    r_mem_wdata;
    logic           r_wb_valid;
    logic [4:0]     r_wb_rd;
    logic [31:0]    r_wb_data;
    logic           r_err_valid;
    logic [1:0]     r_err_cause;
    logic [31:0]    r_err_addr;

    logic           w_accept;
    logic           w_sel_load;
    logic [2:0]     w_sel_fun3;
    logic [1:0]     w_sel_addr_lo;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic           w_misaligned;
    logic           w_illegal;
    logic [31:0]    w_rdata_ext;

    assign w_accept = req_valid_i & r_ready;

    // Checks run on the incoming request in IDLE so errors pulse one cycle after accept;
    // afterwards the latched access drives load extraction.
    assign w_sel_load    = (r_state == ST_IDLE) ? req_load_i      : r_load;
    assign w_sel_fun3    = (r_state == ST_IDLE) ? req_fun3_i      : r_fun3;
    assign w_sel_addr_lo = (r_state == ST_IDLE) ? req_addr_i[1:0] : r_addr[1:0];

    lsu_align u_align (
        .i_load       (w_sel_load),
        .i_fun3       (w_sel_fun3),
        .i_addr_lo    (w_sel_addr_lo),
        .i_wdata      (req_wdata_i),
        .i_rdata      (mem_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal),
        .o_rdata_ext  (w_rdata_ext)
    );

    // Sequencer: accept/check, hold request until grant, wait for data with timeout, respond
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_load      <= 1'b0;
            r_fun3      <= 3'd0;
            r_addr      <= 32'd0;
            r_rd        <= 5'd0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_err_valid <= 1'b0;
            r_err_cause <= 2'd0;
            r_err_addr  <= 32'd0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_err_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_load <= req_load_i;
                        r_fun3 <= req_fun3_i;
                        r_addr <= req_addr_i;
                        r_rd   <= req_rd_i;
                        if (w_illegal || w_misaligned) begin
                            r_err_valid <= 1'b1;
                            r_err_cause <= w_illegal ? ERR_ILLEGAL : ERR_MISALIGNED;
                            r_err_addr  <= req_addr_i;
                        end else begin
                            r_state     <= ST_REQ;
                            r_ready     <= 1'b0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= ~req_load_i;
                            r_mem_be    <= w_be;
                            r_mem_addr  <= {req_addr_i[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        if (r_load) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_rdata_ext;
                        r_state    <= ST_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err_valid <= 1'b1;
                        r_err_cause <= ERR_TIMEOUT;
                        r_err_addr  <= r_addr;
                        r_state     <= ST_IDLE;
                        r_ready     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign busy_o      = ~r_ready;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign wb_valid_o  = r_wb_valid;
    assign wb_rd_o     = r_wb_rd;
    assign wb_data_o   = r_wb_data;
    assign err_valid_o = r_err_valid;
    assign err_cause_o = r_err_cause;
    assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a behavioural access model
module tb_lsu_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_load_i = 1'b0;
    logic [2:0]  req_fun3_i = 3'd0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic [4:0]  req_rd_i = 5'd0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_valid_o;
    logic [1:0]  err_cause_o;
    logic [31:0] err_addr_o;
    logic        busy_o;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_load_i(req_load_i),
        .req_fun3_i(req_fun3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .err_valid_o(err_valid_o), .err_cause_o(err_cause_o), .err_addr_o(err_addr_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_exp_t;
    typedef struct { logic [1:0] cause; logic [31:0] addr; } err_exp_t;

    mem_exp_t exp_mem[$];
    wb_exp_t  exp_wb[$];
    err_exp_t exp_err[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access size in bytes from the width encoding
    function automatic int m_size(input logic [2:0] f3);
        case (f3 % 4)
            0: return 1;
            1: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] m_cause(input logic load, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        int lo;
        lo = int'(addr % 4);
        legal = load ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        if (!legal) return 2'd2;
        if (lo % m_size(f3) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int m;
        m = ((1 << m_size(f3)) - 1) << int'(addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        case (m_size(f3))
            1: return (wdata & 32'hFF) * 32'h0101_0101;
            2: return (wdata & 32'hFFFF) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        longint v;
        longint span;
        int bits;
        v = longint'(rdata) / (longint'(1) << (8 * int'(addr % 4)));
        bits = 8 * m_size(f3);
        if (bits < 32) begin
            span = longint'(1) << bits;
            v = v % span;
            if (f3 < 3'd4 && v >= span / 2) v = v - span;
        end
        return v[31:0];
    endfunction

    // Monitor: compare every DUT output event with the head of its queue
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (mem_req_o) begin
                    if (exp_mem.size() == 0) chk("unexpected_mem_req", 32'(mem_req_o), 32'd0);
                    else begin
                        chk("mem_we", 32'(mem_we_o), 32'(exp_mem[0].we));
                        chk("mem_be", 32'(mem_be_o), 32'(exp_mem[0].be));
                        chk("mem_addr", mem_addr_o, exp_mem[0].addr);
                        if (exp_mem[0].we) chk("mem_wdata", mem_wdata_o, exp_mem[0].wdata);
                        if (mem_gnt_i) void'(exp_mem.pop_front());
                    end
                end
                if (wb_valid_o) begin
                    if (exp_wb.size() == 0) chk("unexpected_wb", 32'(wb_valid_o), 32'd0);
                    else begin
                        wb_exp_t e;
                        e = exp_wb.pop_front();
                        chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
                        chk("wb_data", wb_data_o, e.data);
                    end
                end
                if (err_valid_o) begin
                    if (exp_err.size() == 0) chk("unexpected_err", 32'(err_valid_o), 32'd0);
                    else begin
                        err_exp_t e;
                        e = exp_err.pop_front();
                        chk("err_cause", 32'(err_cause_o), 32'(e.cause));
                        chk("err_addr", err_addr_o, e.addr);
                    end
                end
            end
        end
    end

    // Present a request and wait (bounded) for its accept edge; returns #1 after that edge
    task automatic issue(input logic load, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int n;
        n = 0;
        req_valid_i = 1'b1;
        req_load_i  = load;
        req_fun3_i  = f3;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_rd_i    = rd;
        @(negedge clk_i);
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) chk("ready_wait_expired", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    // One full transaction acting as both execute stage and memory
    task automatic txn(input logic load, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int gdly,
                       input int rdly, input logic [31:0] rdata, input logic tmo);
        logic [1:0] cause;
        cause = m_cause(load, f3, addr);
        if (cause != 2'd0) begin
            exp_err.push_back('{cause: cause, addr: addr});
            issue(load, f3, addr, wdata, rd);
            chk("err_pulse", 32'(err_valid_o), 32'd1);
            chk("err_no_mem", 32'(mem_req_o), 32'd0);
            chk("err_ready", 32'(req_ready_o), 32'd1);
            return;
        end
        exp_mem.push_back('{we: ~load, be: m_be(f3, addr), addr: addr & 32'hFFFF_FFFC,
                            wdata: m_wdata(f3, wdata)});
        issue(load, f3, addr, wdata, rd);
        chk("req_busy", 32'(busy_o), 32'd1);
        repeat (gdly) begin
            @(posedge clk_i);
            #1;
        end
        mem_gnt_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_gnt_i = 1'b0;
        chk("mem_req_drop", 32'(mem_req_o), 32'd0);
        if (!load) begin
            chk("store_ready", 32'(req_ready_o), 32'd1);
            chk("store_no_wb", 32'(wb_valid_o), 32'd0);
            return;
        end
        if (tmo) begin
            exp_err.push_back('{cause: 2'd3, addr: addr});
            repeat (TIMEOUT) @(posedge clk_i);
            #1;
            chk("timeout_pulse", 32'(err_valid_o), 32'd1);
            chk("timeout_idle", 32'(busy_o), 32'd0);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rdata;
            @(posedge clk_i);
            #1;
            mem_rvalid_i = 1'b0;
            chk("late_rvalid_no_wb", 32'(wb_valid_o), 32'd0);
            return;
        end
        repeat (rdly) begin
            @(posedge clk_i);
            #1;
        end
        exp_wb.push_back('{rd: rd, data: m_load(f3, addr, rdata)});
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        chk("resp_pulse", 32'(wb_valid_o), 32'd1);
        chk("resp_busy", 32'(req_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("resp_one_cycle", 32'(wb_valid_o), 32'd0);
        chk("resp_ready", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_err_valid", 32'(err_valid_o), 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        rst_i = 1'b0;

        txn(1'b0, 3'd2, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0, 1'b0);
        txn(1'b1, 3'd0, 32'h203, 32'd0, 5'd7, 0, 2, 32'h80FF_1234, 1'b0);
        txn(1'b1, 3'd4, 32'h203, 32'd0, 5'd9, 0, 2, 32'h80FF_1234, 1'b0);
        txn(1'b0, 3'd1, 32'h002, 32'h0000_ABCD, 5'd0, 4, 0, 32'd0, 1'b0);
        txn(1'b1, 3'd2, 32'h101, 32'd0, 5'd3, 0, 0, 32'd0, 1'b0);
        txn(1'b1, 3'd3, 32'h200, 32'd0, 5'd3, 0, 0, 32'd0, 1'b0);
        txn(1'b0, 3'd5, 32'h201, 32'h1234, 5'd0, 0, 0, 32'd0, 1'b0);
        txn(1'b1, 3'd2, 32'h400, 32'd0, 5'd0, 1, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);
        txn(1'b1, 3'd1, 32'h402, 32'd0, 5'd5, 0, 0, 32'h8001_7FFF, 1'b0);
        txn(1'b1, 3'd5, 32'h402, 32'd0, 5'd6, 0, 0, 32'h8001_7FFF, 1'b0);
        txn(1'b1, 3'd2, 32'h500, 32'd0, 5'd8, 0, 0, 32'h1111_2222, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic        ld;
            logic [2:0]  f3;
            logic [31:0] a;
            ld = 1'($urandom);
            f3 = 3'($urandom);
            a  = $urandom;
            txn(ld, f3, a, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), $urandom, 1'b0);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk_i);
                #1;
            end
        end

        // Reset while a load waits for data
        exp_mem.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h600, wdata: 32'd0});
        issue(1'b1, 3'd2, 32'h600, 32'd0, 5'd4);
        mem_gnt_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_gnt_i = 1'b0;
        chk("wait_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_wait_busy", 32'(busy_o), 32'd0);
        chk("rst_wait_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_wait_ready", 32'(req_ready_o), 32'd1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        chk("rst_rvalid_ignored", 32'(wb_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("rst_rvalid_ignored2", 32'(wb_valid_o), 32'd0);
        chk("rst_still_idle", 32'(busy_o), 32'd0);

        repeat (2) @(posedge clk_i);
        #1;
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        chk("wb_queue_empty", 32'(exp_wb.size()), 32'd0);
        chk("err_queue_empty", 32'(exp_err.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer for the RV32I core. It takes one decoded LOAD/STORE request per handshake from the execute stage and checks alignment and fun3. It then drives a single-outstanding req/gnt/rvalid data-memory port and returns sign- or zero-extended load data to write-back. It also raises a stall (busy) to the pipeline while a transaction is in flight.

Parameters:
TIMEOUT, 16, cycles allowed in WAIT for mem_rvalid_i before a timeout error is reported (must be >= 2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  execute stage presents a load/store
req_ready_o  out  1  controller can accept a request (IDLE only)
req_load_i  in  1  1 = LOAD, 0 = STORE
req_fun3_i  in  3  instruction[14:12]
req_addr_i  in  32  effective address rs1+imm
req_wdata_i  in  32  rs2 value for stores
req_rd_i  in  5  load destination register
mem_req_o  out  1  memory request, held until granted
mem_we_o  out  1  1 = write
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  memory accepts request this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data word
wb_valid_o  out  1  one-cycle pulse, load result ready
wb_rd_o  out  5  load destination
wb_data_o  out  32  extended load data
err_valid_o  out  1  one-cycle error pulse
err_cause_o  out  2  01 misaligned, 10 illegal fun3, 11 timeout
err_addr_o  out  32  faulting req address
busy_o  out  1  state != IDLE (pipeline stall)

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready_o = 1; the timeout counter is cleared.
- Reset mid-transaction abandons the access. mem_req_o is low in the cycle after reset, and any later mem_rvalid_i is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid_i & req_ready_o, latch load, fun3, addr, wdata and rd.
  - Illegal fun3 (load 3/6/7; store 3..7): err cause 10.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): err cause 01. Illegal takes priority over misaligned.
  - Error path: err_valid_o pulses in the next cycle with err_addr_o = latched addr; no memory access; stay IDLE.
  - Otherwise go to REQ.
- REQ: mem_req_o = 1 with mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o stable until mem_gnt_i.
  - On gnt: a store returns to IDLE; a load goes to WAIT with the counter cleared.
  - mem_rvalid_i is ignored in REQ.
- WAIT (load): on mem_rvalid_i, register the extended data into wb_data_o and wb_rd_o, then go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without rvalid, pulse err cause 11 and return to IDLE.
- RESP: wb_valid_o = 1 for exactly one cycle, then IDLE.
- rd = 0 loads are still performed and written back; the register file discards them.
- Byte enables:
  - SB/LB/LBU: 4'b0001 << addr[1:0].
  - SH/LH/LHU: 4'b0011 << addr[1:0].
  - W: 4'b1111.
  - Loads drive the same BE values with mem_we_o = 0.
- Store data: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
- Load extract: shift rdata right by 8*addr[1:0], then apply 8/16-bit sign (LB/LH) or zero (LBU/LHU) extension. LW passes the word through.
- Latency with immediate gnt:
  - Accept at T; mem_req_o at T+1; gnt at T+1.
  - rvalid at T+2 gives wb_valid_o at T+3.
  - The next accept is possible at T+4.
  - A store completes at T+1 and its next accept is possible at T+2.
- req_ready_o = (state == IDLE) and is registered. The cycle in which an error pulse is issued is IDLE, so a new request may be accepted in that cycle.
- mem_req_o and wb/err outputs are registered (glitch-free).

Decomposition:
- Shared package rv32_pkg holds:
  - fun3 constants F3_B = 0, F3_H = 1, F3_W = 2, F3_BU = 4, F3_HU = 5;
  - opcode constants OP_LOAD = 5'b00000, OP_STORE = 5'b01000;
  - LSU state enum;
  - error-cause constants.
- One combinational sub-module, lsu_align, computes byte enables, lane-replicated store data, the misaligned/illegal flags, and load extraction. lsu_ctrl holds the FSM, latches and timeout counter.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, gnt in the first REQ cycle -> mem_req_o = 1 one cycle, be = 1111, addr = 0x100, we = 1; back in IDLE next cycle; no wb_valid_o.
- LB addr 0x203, rdata 0x80FF_1234 arriving 3 cycles after gnt -> wb_data_o = 0xFFFFFF80, wb_rd_o = req rd, be = 1000; same with LBU -> 0x00000080.
- SH addr 0x002, wdata 0x0000ABCD, gnt delayed 4 cycles -> mem_req_o stays high with stable be = 1100 and wdata = 0xABCDABCD until gnt.
- LW addr 0x101 -> err_valid_o pulse, cause 01, err_addr_o = 0x101, mem_req_o never asserted; load fun3 = 3 -> cause 10.
- Load granted, no rvalid for TIMEOUT = 16 -> err cause 11 after 16 WAIT cycles; a late rvalid afterwards produces no wb_valid_o.
- rst_i asserted in WAIT -> next cycle busy_o = 0, mem_req_o = 0, req_ready_o = 1; a subsequent rvalid is ignored.
